// File: rtl/dac_ad5322_if.sv
// dac_ad5322_if: serial write engine for the dual 12-bit AD5322 DAC.
// Latency: accept at cycle 0, SYNC_n low cycles 1..32*CLK_DIV, done on the last GAP cycle.
// Backpressure: req_ready is high only in IDLE; requests arriving while busy are held off, never queued.
//
// Ports
//   clk_sys, RESET_N          system clock, asynchronous active-low reset
//   req_valid / req_ready     one channel update per handshake
//   req_ch, req_buf, req_pd,  frame fields {ch, buf, pd[1:0], data[11:0]}, latched at accept
//   req_data
//   req_ldac                  pulse LDAC_n after this frame
//   busy, done                ~req_ready; one-cycle completion pulse
//   oDA_SCLK/DOUT/SYNC_n/     DAC pins; SCLK idles high, data MSB first,
//   oDA_LDAC_n                DAC samples DOUT on the falling SCLK edge
//
// Build option: define DAC_DEDUP_EN to keep a per-channel shadow of the last
// transmitted word and skip frames that would not change the DAC (ldac=0 only).

module dac_ad5322_if #(
    parameter int CLK_DIV    = 4,
    parameter int LDAC_WIDTH = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_ch,
    input  logic        req_buf,
    input  logic [1:0]  req_pd,
    input  logic [11:0] req_data,
    input  logic        req_ldac,
    output logic        busy,
    output logic        done,
    output logic        oDA_SCLK,
    output logic        oDA_DOUT,
    output logic        oDA_SYNC_n,
    output logic        oDA_LDAC_n
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int LW_W  = $clog2(LDAC_WIDTH + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_TC  = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [LW_W-1:0]  LW_TC   = LW_W'(LDAC_WIDTH);
    localparam logic [GAP_W-1:0] GAP_TC  = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
    // With a single-cycle gap the first GAP cycle is also the last one.
    localparam logic             GAP_IS_ONE = 1'(GAP_CYCLES == 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LDAC  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t             state;
    logic [15:0]        shreg;        // bits still to send, next bit in [15]
    logic [3:0]         bit_cnt;      // 15..0, index of the bit currently on DOUT
    logic [DIV_W-1:0]   div_cnt;      // cycles spent in the current SCLK phase
    logic [LW_W-1:0]    ldac_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               ldac_pending;

    logic [15:0]        req_word;
    logic               dedup_hit;

    assign req_word = {req_ch, req_buf, req_pd, req_data};
    assign busy     = ~req_ready;

`ifdef DAC_DEDUP_EN
    logic [15:0] shadow_a;
    logic [15:0] shadow_b;

    // A frame that repeats the channel's last word changes nothing at the
    // DAC unless an LDAC pulse was asked for.
    assign dedup_hit = !req_ldac &&
                       ((req_ch ? shadow_b : shadow_a) == req_word);

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            shadow_a <= 16'hFFFF;
            shadow_b <= 16'hFFFF;
        end else if (state == ST_IDLE && req_valid && !dedup_hit) begin
            if (req_ch) begin
                shadow_b <= req_word;
            end else begin
                shadow_a <= req_word;
            end
        end
    end
`else
    assign dedup_hit = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= ST_IDLE;
            req_ready    <= 1'b1;
            done         <= 1'b0;
            oDA_SCLK     <= 1'b1;
            oDA_DOUT     <= 1'b0;
            oDA_SYNC_n   <= 1'b1;
            oDA_LDAC_n   <= 1'b1;
            shreg        <= 16'h0000;
            bit_cnt      <= 4'd0;
            div_cnt      <= '0;
            ldac_cnt     <= '0;
            gap_cnt      <= '0;
            ldac_pending <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready    <= 1'b0;
                        ldac_pending <= req_ldac;
                        if (dedup_hit) begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_ONE;
                            done    <= GAP_IS_ONE;
                        end else begin
                            // SCLK is already high, so putting bit 15 out
                            // with the SYNC_n fall is the first rising phase.
                            state      <= ST_SHIFT;
                            oDA_SYNC_n <= 1'b0;
                            oDA_SCLK   <= 1'b1;
                            oDA_DOUT   <= req_word[15];
                            shreg      <= {req_word[14:0], 1'b0};
                            bit_cnt    <= 4'd15;
                            div_cnt    <= DIV_ONE;
                        end
                    end
                end

                ST_SHIFT: begin
                    if (div_cnt != DIV_TC) begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end else if (oDA_SCLK) begin
                        // End of the high phase: falling edge, DOUT holds.
                        oDA_SCLK <= 1'b0;
                        div_cnt  <= DIV_ONE;
                    end else if (bit_cnt == 4'd0) begin
                        // Low phase of bit 0 finished: close the frame with
                        // SCLK back high so no extra edge lands inside SYNC_n.
                        oDA_SCLK   <= 1'b1;
                        oDA_SYNC_n <= 1'b1;
                        oDA_DOUT   <= 1'b0;
                        if (ldac_pending) begin
                            state    <= ST_LDAC;
                            ldac_cnt <= '0;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= GAP_ONE;
                            done    <= GAP_IS_ONE;
                        end
                    end else begin
                        // Rising edge: the only place DOUT moves mid-frame.
                        oDA_SCLK <= 1'b1;
                        oDA_DOUT <= shreg[15];
                        shreg    <= {shreg[14:0], 1'b0};
                        bit_cnt  <= bit_cnt - 4'd1;
                        div_cnt  <= DIV_ONE;
                    end
                end

                ST_LDAC: begin
                    // First cycle here keeps LDAC_n high (SYNC_n-to-LDAC
                    // setup), then LDAC_WIDTH cycles low.
                    if (ldac_cnt == LW_TC) begin
                        oDA_LDAC_n <= 1'b1;
                        state      <= ST_GAP;
                        gap_cnt    <= GAP_ONE;
                        done       <= GAP_IS_ONE;
                    end else begin
                        oDA_LDAC_n <= 1'b0;
                        ldac_cnt   <= ldac_cnt + LW_W'(1);
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_TC) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_ONE;
                        done    <= ((gap_cnt + GAP_ONE) == GAP_TC);
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
